// File: rtl/ht_cmd_arbiter.sv
// Round-robin merge of NUM_SRC command streams into one registered valid/ready output.
// Optional per-source grant counters are built when HT_ARB_STATS_EN is defined.
module ht_cmd_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int CMD_W   = 64,
    parameter int SRC_W   = $clog2(NUM_SRC),
    parameter int STAT_W  = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_SRC*CMD_W-1:0] src_cmd_i,
    input  logic [NUM_SRC-1:0]       src_valid_i,
    output logic [NUM_SRC-1:0]       src_ready_o,
    output logic [CMD_W-1:0]         cmd_o,
    output logic [SRC_W-1:0]         cmd_src_o,
    output logic                     cmd_valid_o,
    input  logic                     cmd_ready_i,
    input  logic [SRC_W-1:0]         stat_sel_i,
    input  logic                     stat_clr_i,
    output logic [STAT_W-1:0]        stat_cnt_o
);

    // Valid/ready: a transfer happens on a rising edge where valid and ready are
    // both high. Sources hold cmd/valid until ready; ready never depends on a
    // later cycle, and the output stage holds cmd/src/valid while cmd_ready_i is low.

    logic [SRC_W-1:0] rr_ptr;
    logic [SRC_W-1:0] rr_next;
    logic [SRC_W-1:0] grant_idx;
    logic             grant_found;
    logic [SRC_W:0]   search_idx;
    logic [CMD_W-1:0] grant_cmd;
    logic             load;
    logic             handshake;

    assign load      = !cmd_valid_o || cmd_ready_i;
    assign handshake = rst_i && load && grant_found;

    // Search starts at rr_ptr and wraps at NUM_SRC, which need not be a power of two.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        search_idx  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            search_idx = {1'b0, rr_ptr} + (SRC_W+1)'(i);
            if (search_idx >= (SRC_W+1)'(NUM_SRC)) begin
                search_idx = search_idx - (SRC_W+1)'(NUM_SRC);
            end
            if (!grant_found && src_valid_i[search_idx[SRC_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = search_idx[SRC_W-1:0];
            end
        end
    end

    assign grant_cmd = src_cmd_i[int'(grant_idx)*CMD_W +: CMD_W];
    assign rr_next   = (grant_idx == SRC_W'(NUM_SRC-1)) ? '0 : grant_idx + SRC_W'(1);

    always_comb begin
        src_ready_o = '0;
        if (handshake) begin
            src_ready_o[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cmd_o       <= '0;
            cmd_src_o   <= '0;
            cmd_valid_o <= 1'b0;
            rr_ptr      <= '0;
        end else if (load) begin
            if (grant_found) begin
                cmd_o       <= grant_cmd;
                cmd_src_o   <= grant_idx;
                cmd_valid_o <= 1'b1;
                rr_ptr      <= rr_next;
            end else begin
                // Drained with nothing to send: payload keeps its last value.
                cmd_valid_o <= 1'b0;
            end
        end
    end

`ifdef HT_ARB_STATS_EN
    logic [STAT_W-1:0] stat_cnt [NUM_SRC];

    // Clear wins over a same-cycle increment.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                stat_cnt[k] <= '0;
            end
        end else if (stat_clr_i) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                stat_cnt[k] <= '0;
            end
        end else if (handshake) begin
            stat_cnt[grant_idx] <= stat_cnt[grant_idx] + STAT_W'(1);
        end
    end

    assign stat_cnt_o = (int'(stat_sel_i) < NUM_SRC) ? stat_cnt[stat_sel_i] : '0;
`else
    logic stats_unused;
    assign stats_unused = ^{stat_sel_i, stat_clr_i};
    assign stat_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_ht_cmd_arbiter.sv
// Directed bench for ht_cmd_arbiter: vector table plus reset/stall/statistics sequences.
// Statistics checks are compiled in when HT_ARB_STATS_EN is defined.
module tb_ht_cmd_arbiter;

    localparam int NUM_SRC = 4;
    localparam int CMD_W   = 64;
    localparam int SRC_W   = 2;
    localparam int STAT_W  = 32;

    localparam logic [63:0] C0 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] C1 = 64'hDEAD_BEEF_0000_0001;
    localparam logic [63:0] C2 = 64'h0000_0000_0000_00A5;
    localparam logic [63:0] C3 = 64'hFFFF_0000_FFFF_0003;

    logic                     clk;
    logic                     rst_n;
    logic [NUM_SRC*CMD_W-1:0] src_cmd;
    logic [NUM_SRC-1:0]       src_valid;
    logic [NUM_SRC-1:0]       src_ready;
    logic [CMD_W-1:0]         cmd;
    logic [SRC_W-1:0]         cmd_src;
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [SRC_W-1:0]         stat_sel;
    logic                     stat_clr;
    logic [STAT_W-1:0]        stat_cnt;

    int n_cmp;
    int n_err;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    ht_cmd_arbiter #(.NUM_SRC(NUM_SRC), .CMD_W(CMD_W), .SRC_W(SRC_W), .STAT_W(STAT_W)) dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .src_cmd_i   (src_cmd),
        .src_valid_i (src_valid),
        .src_ready_o (src_ready),
        .cmd_o       (cmd),
        .cmd_src_o   (cmd_src),
        .cmd_valid_o (cmd_valid),
        .cmd_ready_i (cmd_ready),
        .stat_sel_i  (stat_sel),
        .stat_clr_i  (stat_clr),
        .stat_cnt_o  (stat_cnt)
    );

`ifdef HT_ARB_STATS_EN
    logic [5*CMD_W-1:0] s5_cmd;
    logic [4:0]         s5_valid;
    logic [4:0]         s5_ready;
    logic [CMD_W-1:0]   s5_out_cmd;
    logic [2:0]         s5_out_src;
    logic               s5_out_valid;
    logic [2:0]         s5_sel;
    logic [STAT_W-1:0]  s5_cnt;

    ht_cmd_arbiter #(.NUM_SRC(5), .CMD_W(CMD_W), .SRC_W(3), .STAT_W(STAT_W)) dut5 (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .src_cmd_i   (s5_cmd),
        .src_valid_i (s5_valid),
        .src_ready_o (s5_ready),
        .cmd_o       (s5_out_cmd),
        .cmd_src_o   (s5_out_src),
        .cmd_valid_o (s5_out_valid),
        .cmd_ready_i (1'b1),
        .stat_sel_i  (s5_sel),
        .stat_clr_i  (1'b0),
        .stat_cnt_o  (s5_cnt)
    );
`endif

    typedef struct {
        logic [3:0]  valid;
        logic        rdy;
        logic [3:0]  exp_srdy;
        logic        exp_v;
        logic [1:0]  exp_src;
        logic [63:0] exp_cmd;
    } vec_t;

    localparam int NV = 27;
    vec_t vec [NV];

    // scoreboard compare
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] v, input logic r);
        src_valid = v;
        cmd_ready = r;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n     = 1'b0;
        src_cmd   = {C3, C2, C1, C0};
        stat_sel  = '0;
        stat_clr  = 1'b0;
`ifdef HT_ARB_STATS_EN
        s5_cmd   = '0;
        s5_valid = '0;
        s5_sel   = '0;
`endif
        drive(4'b1111, 1'b1);

        // round-robin from pointer 0, then single/idle/fairness/backpressure patterns
        vec[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, C0};
        vec[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, C1};
        vec[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, C2};
        vec[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, C3};
        vec[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, C0};
        vec[5]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, C1};
        vec[6]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, C2};
        vec[7]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, C3};
        vec[8]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, C2};
        vec[9]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, C2};
        vec[10] = '{4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, C3};
        vec[11] = '{4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0, C0};
        vec[12] = '{4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, C3};
        vec[13] = '{4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, C1};
        vec[14] = '{4'b0110, 1'b0, 4'b0000, 1'b1, 2'd1, C1};
        vec[15] = '{4'b0110, 1'b0, 4'b0000, 1'b1, 2'd1, C1};
        vec[16] = '{4'b0110, 1'b0, 4'b0000, 1'b1, 2'd1, C1};
        vec[17] = '{4'b0110, 1'b0, 4'b0000, 1'b1, 2'd1, C1};
        vec[18] = '{4'b0110, 1'b0, 4'b0000, 1'b1, 2'd1, C1};
        vec[19] = '{4'b0110, 1'b1, 4'b0100, 1'b1, 2'd2, C2};
        vec[20] = '{4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, C1};
        vec[21] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'd1, C1};
        vec[22] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, C1};
        vec[23] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, C0};
        vec[24] = '{4'b0101, 1'b0, 4'b0000, 1'b1, 2'd0, C0};
        vec[25] = '{4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2, C2};
        vec[26] = '{4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0, C0};

        // reset held with all sources requesting
        #3;
        check("rst_src_ready", 64'(src_ready), 64'h0);
        check("rst_cmd_valid", 64'(cmd_valid), 64'h0);
        step();
        step();
        check("rst_src_ready_2", 64'(src_ready), 64'h0);
        check("rst_cmd_valid_2", 64'(cmd_valid), 64'h0);
        check("rst_cmd", cmd, 64'h0);
        check("rst_cmd_src", 64'(cmd_src), 64'h0);
        drive(4'b0000, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("idle_valid[%0d]", i), 64'(cmd_valid), 64'h0);
        end

        // vector table
        for (int i = 0; i < NV; i++) begin
            stat_sel = SRC_W'(i);
            drive(vec[i].valid, vec[i].rdy);
            #1;
            check($sformatf("v%0d_src_ready", i), 64'(src_ready), 64'(vec[i].exp_srdy));
            step();
            check($sformatf("v%0d_cmd_valid", i), 64'(cmd_valid), 64'(vec[i].exp_v));
            check($sformatf("v%0d_cmd_src", i), 64'(cmd_src), 64'(vec[i].exp_src));
            check($sformatf("v%0d_cmd", i), cmd, vec[i].exp_cmd);
`ifndef HT_ARB_STATS_EN
            check($sformatf("v%0d_stat_tied", i), 64'(stat_cnt), 64'h0);
`endif
        end

        // reset mid-stall drops the held command and returns the pointer to 0
        drive(4'b0000, 1'b0);
        step();
        check("stall_hold_valid", 64'(cmd_valid), 64'h1);
        drive(4'b1111, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 64'(cmd_valid), 64'h0);
        check("midrst_cmd", cmd, 64'h0);
        check("midrst_src_ready", 64'(src_ready), 64'h0);
        step();
        rst_n = 1'b1;
        #1;
        check("postrst_src_ready", 64'(src_ready), 64'h1);
        step();
        check("postrst_cmd_src", 64'(cmd_src), 64'h0);
        check("postrst_cmd", cmd, C0);

`ifdef HT_ARB_STATS_EN
        // clear, ten grants to source 1, then clear against a coincident grant
        drive(4'b0000, 1'b1);
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            stat_sel = SRC_W'(k);
            #1;
            check($sformatf("clr_cnt[%0d]", k), 64'(stat_cnt), 64'h0);
        end
        drive(4'b0010, 1'b1);
        for (int i = 0; i < 10; i++) step();
        stat_sel = 2'd1;
        #1;
        check("cnt1_after_10", 64'(stat_cnt), 64'd10);
        stat_sel = 2'd0;
        #1;
        check("cnt0_untouched", 64'(stat_cnt), 64'd0);
        stat_sel = 2'd1;
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        drive(4'b0000, 1'b1);
        check("clr_beats_incr", 64'(stat_cnt), 64'd0);

        // out-of-range select on a five-source instance
        s5_valid = 5'b00001;
        for (int i = 0; i < 3; i++) step();
        s5_valid = 5'b00000;
        s5_sel = 3'd0;
        #1;
        check("s5_cnt0", 64'(s5_cnt), 64'd3);
        for (int k = 5; k < 8; k++) begin
            s5_sel = 3'(k);
            #1;
            check($sformatf("s5_sel_oob[%0d]", k), 64'(s5_cnt), 64'd0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
